nanci_sort_sched: RTL and testbench
===================================

# nanci_sort_sched

Mesh-wide phase scheduler for the Nanci PE array. It broadcasts one command per cycle to every PE, sequencing a snake-order shearsort over a SQRT_N x SQRT_N mesh and then a compute window. The sort is a series of odd-even transposition steps on rows and columns. Each PE decodes the command locally, using its own row and column parity, to pick the L/R/U/D neighbour input. The block sits beside the mesh top level and is the only source of PE sequencing.

## Interface
- SQRT_N, 4, mesh side length; power of two, minimum 2
- LOG_SQRT_N, 2, log2(SQRT_N)
- STEP_CYCLES, 1, cycles per transposition step (minimum 1)
- COMPUTE_CYCLES, 1, length of the compute window (minimum 1)
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset)
- i_start  in  1  request a sort+compute run; sampled only in IDLE
- i_hold  in  1  stall: freeze all counters and state
- o_busy  out  1  high from the first ROW cycle through the DONE cycle
- o_done  out  1  one-cycle pulse in the DONE state
- o_op  out  2  00 NOP, 01 ROW_XCHG, 10 COL_XCHG, 11 COMPUTE
- o_parity  out  1  step parity; meaningful during XCHG commands
- o_snake  out  1  high during ROW_XCHG; odd rows sort descending
- o_phase  out  4  current sort phase index, 0-based
- o_step  out  LOG_SQRT_N  step index within the current phase

## Operation
- Sort phase count P = 2*LOG_SQRT_N+1, ordered ROW, COL, ROW, COL, …, ROW.
  - Even phase index → ROW; odd phase index → COL.
  - Requirement: P ≤ 15.
- Each phase has SQRT_N steps; each step lasts STEP_CYCLES cycles.
- o_parity = step index LSB (step 0 even, step 1 odd, …).
- States and transitions:
  - IDLE: o_op=NOP. If i_start=1, go to ROW with phase=0, step=0, cycle=0.
  - ROW / COL:
    - The cycle counter counts to STEP_CYCLES-1, then step increments.
    - After step SQRT_N-1 completes, phase increments; the next state is ROW or COL by phase parity.
    - After phase P-1 completes, go to COMPUTE.
  - COMPUTE: o_op=11 for COMPUTE_CYCLES cycles, then go to DONE.
  - DONE: o_done=1 and o_op=NOP for one cycle, then go to IDLE.
- i_start while not in IDLE is ignored; no queuing.
- i_hold=1 in any non-IDLE state:
  - State, phase, step and cycle counters hold.
  - o_op is forced to NOP; o_busy stays 1.
  - o_done is suppressed while held: DONE persists until a non-held cycle.
- i_hold in IDLE has no effect; i_start is still accepted.
- o_phase and o_step read 0 in IDLE, COMPUTE and DONE.
- o_snake=0 outside ROW.
- Counter wrap: step and cycle counters reset to 0 at each boundary. o_step never exceeds SQRT_N-1.

## Timing
- All outputs are registered and decoded from state/counter registers; no combinational path from any input to any output.
- Reset values: state IDLE, o_busy 0, o_done 0, o_op 00, o_parity 0, o_snake 0, o_phase 0, o_step 0.
- Reset asserted mid-run returns the block to IDLE immediately, asynchronously. The run is aborted and o_done is not pulsed.
- Latency: if i_start is high at edge k, the first ROW_XCHG is visible after edge k+1.
- Run length with no hold: P*SQRT_N*STEP_CYCLES + COMPUTE_CYCLES + 1 cycles, all with o_busy=1.
- Each hold cycle extends the run by exactly one cycle.
- i_start may be re-asserted in the cycle after DONE, with no dead cycle beyond IDLE.

## Test plan
- **Basic run.** SQRT_N=2, LOG_SQRT_N=1, STEP_CYCLES=1, COMPUTE_CYCLES=1; pulse i_start at cycle 0.
  - Cycles 1–6 o_op/o_phase/o_parity: ROW/0/0, ROW/0/1, COL/1/0, COL/1/1, ROW/2/0, ROW/2/1.
  - Cycle 7 COMPUTE; cycle 8 o_done=1; cycle 9 o_busy=0.
- **Reset values.** Hold rst=0 for 2 cycles → every output is 0; i_start is ignored while rst=0.
- **Hold.** Same config; i_hold=1 in cycles 3–4 → o_op=NOP in those cycles, COL/1/0 resumes at cycle 5, o_done at cycle 10.
- **Stretched steps.** STEP_CYCLES=2, SQRT_N=4, LOG_SQRT_N=2, COMPUTE_CYCLES=3.
  - 40 XCHG cycles, each (phase, step) value held for 2 cycles.
  - o_snake=1 only in phases 0, 2 and 4; o_done at cycle 44.
- **Reset mid-run and restart.** Assert rst=0 during phase 1 step 1 → outputs clear within the same cycle and no o_done pulse occurs. Re-run with i_start → full sequence repeats from phase 0.
- **Start while busy.** i_start held high continuously → each run is separated by exactly one IDLE cycle. Pulses of i_start mid-run are ignored.

Source files
------------

// File: rtl/nanci_sort_sched.sv
// Mesh-wide shearsort phase scheduler for the Nanci PE array.
// Broadcasts one registered command per cycle: row/column transposition steps, then a compute window.
module nanci_sort_sched #(
    parameter int SQRT_N         = 4,
    parameter int LOG_SQRT_N     = 2,
    parameter int STEP_CYCLES    = 1,
    parameter int COMPUTE_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_hold,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_op,
    output logic                  o_parity,
    output logic                  o_snake,
    output logic [3:0]            o_phase,
    output logic [LOG_SQRT_N-1:0] o_step
);

    localparam int NUM_PHASES = 2 * LOG_SQRT_N + 1;
    localparam int CNT_MAX    = (STEP_CYCLES > COMPUTE_CYCLES) ? STEP_CYCLES : COMPUTE_CYCLES;
    localparam int CNT_W      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]      CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]      CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]      STEP_LAST  = CNT_W'(STEP_CYCLES - 1);
    localparam logic [CNT_W-1:0]      COMP_LAST  = CNT_W'(COMPUTE_CYCLES - 1);
    localparam logic [LOG_SQRT_N-1:0] STEP_ZERO  = LOG_SQRT_N'(0);
    localparam logic [LOG_SQRT_N-1:0] STEP_ONE   = LOG_SQRT_N'(1);
    localparam logic [LOG_SQRT_N-1:0] STEP_IDX_LAST = LOG_SQRT_N'(SQRT_N - 1);
    localparam logic [3:0]            PHASE_ZERO = 4'd0;
    localparam logic [3:0]            PHASE_ONE  = 4'd1;
    localparam logic [3:0]            PHASE_LAST = 4'(NUM_PHASES - 1);

    localparam logic [1:0] OP_NOP     = 2'b00;
    localparam logic [1:0] OP_ROW     = 2'b01;
    localparam logic [1:0] OP_COL     = 2'b10;
    localparam logic [1:0] OP_COMPUTE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ROW     = 3'd1,
        ST_COL     = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t                  state_r;
    logic [3:0]              phase_r;
    logic [LOG_SQRT_N-1:0]   step_r;
    logic [CNT_W-1:0]        cnt_r;
    logic                    held_s;
    logic                    xchg_s;

    assign held_s = i_hold && (state_r != ST_IDLE);
    assign xchg_s = (state_r == ST_ROW) || (state_r == ST_COL);

    // Outputs decode the pre-edge state (one cycle behind the state), then state/counters advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            phase_r  <= PHASE_ZERO;
            step_r   <= STEP_ZERO;
            cnt_r    <= CNT_ZERO;
            o_busy   <= 1'b0;
            o_done   <= 1'b0;
            o_op     <= OP_NOP;
            o_parity <= 1'b0;
            o_snake  <= 1'b0;
            o_phase  <= PHASE_ZERO;
            o_step   <= STEP_ZERO;
        end else begin
            o_busy   <= (state_r != ST_IDLE);
            o_done   <= (state_r == ST_DONE) && !i_hold;
            o_snake  <= (state_r == ST_ROW) && !i_hold;
            o_parity <= xchg_s ? step_r[0] : 1'b0;
            o_phase  <= xchg_s ? phase_r : PHASE_ZERO;
            o_step   <= xchg_s ? step_r : STEP_ZERO;

            if (held_s) begin
                o_op <= OP_NOP;
            end else begin
                case (state_r)
                    ST_ROW:     o_op <= OP_ROW;
                    ST_COL:     o_op <= OP_COL;
                    ST_COMPUTE: o_op <= OP_COMPUTE;
                    default:    o_op <= OP_NOP;
                endcase
            end

            // A held cycle freezes state and every counter
            if (!held_s) begin
                case (state_r)
                    ST_IDLE: begin
                        if (i_start) begin
                            state_r <= ST_ROW;
                            phase_r <= PHASE_ZERO;
                            step_r  <= STEP_ZERO;
                            cnt_r   <= CNT_ZERO;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_ROW, ST_COL: begin
                        if (cnt_r == STEP_LAST) begin
                            cnt_r <= CNT_ZERO;
                            if (step_r == STEP_IDX_LAST) begin
                                step_r <= STEP_ZERO;
                                if (phase_r == PHASE_LAST) begin
                                    phase_r <= PHASE_ZERO;
                                    state_r <= ST_COMPUTE;
                                end else begin
                                    phase_r <= phase_r + PHASE_ONE;
                                    // next phase is even (ROW) when the current one is odd
                                    state_r <= phase_r[0] ? ST_ROW : ST_COL;
                                end
                            end else begin
                                step_r <= step_r + STEP_ONE;
                            end
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    ST_COMPUTE: begin
                        if (cnt_r == COMP_LAST) begin
                            cnt_r   <= CNT_ZERO;
                            state_r <= ST_DONE;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    ST_DONE: begin
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        state_r <= ST_IDLE;
                        phase_r <= PHASE_ZERO;
                        step_r  <= STEP_ZERO;
                        cnt_r   <= CNT_ZERO;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nanci_sort_sched.sv
// Bench for nanci_sort_sched: two configurations checked every cycle against a command-list model.
module tb_nanci_sort_sched;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] phase;
        logic [3:0] step;
        logic       parity;
        logic       snake;
        logic       done;
    } item_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, hold_a, start_b, hold_b;
    logic busy_a, done_a, parity_a, snake_a;
    logic [1:0] op_a;
    logic [3:0] phase_a;
    logic [0:0] step_a;
    logic busy_b, done_b, parity_b, snake_b;
    logic [1:0] op_b;
    logic [3:0] phase_b;
    logic [1:0] step_b;

    nanci_sort_sched #(.SQRT_N(2), .LOG_SQRT_N(1), .STEP_CYCLES(1), .COMPUTE_CYCLES(1)) dut_a (
        .clk(clk), .rst(rst), .i_start(start_a), .i_hold(hold_a),
        .o_busy(busy_a), .o_done(done_a), .o_op(op_a), .o_parity(parity_a),
        .o_snake(snake_a), .o_phase(phase_a), .o_step(step_a)
    );

    nanci_sort_sched #(.SQRT_N(4), .LOG_SQRT_N(2), .STEP_CYCLES(2), .COMPUTE_CYCLES(3)) dut_b (
        .clk(clk), .rst(rst), .i_start(start_b), .i_hold(hold_b),
        .o_busy(busy_b), .o_done(done_b), .o_op(op_b), .o_parity(parity_b),
        .o_snake(snake_b), .o_phase(phase_b), .o_step(step_b)
    );

    int    n_tests = 0;
    int    n_fail  = 0;
    item_t lst [2][64];
    int    len [2];
    bit    run [2];
    int    idx [2];
    logic  e_busy [2];
    item_t e_it [2];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // The whole run as a list of per-cycle commands, straight from the phase/step rules
    function automatic void build(input int d, input int n, input int logn, input int sc, input int cc);
        int k;
        k = 0;
        for (int p = 0; p < 2 * logn + 1; p++)
            for (int s = 0; s < n; s++)
                for (int c = 0; c < sc; c++) begin
                    lst[d][k] = '{op: (p % 2 == 0) ? 2'b01 : 2'b10, phase: 4'(p), step: 4'(s),
                                  parity: 1'(s % 2), snake: (p % 2 == 0), done: 1'b0};
                    k++;
                end
        for (int c = 0; c < cc; c++) begin
            lst[d][k] = '{op: 2'b11, phase: 4'd0, step: 4'd0, parity: 1'b0, snake: 1'b0, done: 1'b0};
            k++;
        end
        lst[d][k] = '{op: 2'b00, phase: 4'd0, step: 4'd0, parity: 1'b0, snake: 1'b0, done: 1'b1};
        k++;
        len[d] = k;
    endfunction

    function automatic void model_idle(input int d);
        run[d]    = 1'b0;
        idx[d]    = 0;
        e_busy[d] = 1'b0;
        e_it[d]   = '0;
    endfunction

    // One clock edge: emit the current list entry (or its held form), then advance
    function automatic void model_edge(input int d, input logic start, input logic hold);
        item_t it;
        if (!run[d]) begin
            e_busy[d] = 1'b0;
            e_it[d]   = '0;
            if (start) begin
                run[d] = 1'b1;
                idx[d] = 0;
            end
        end else begin
            it = lst[d][idx[d]];
            e_busy[d] = 1'b1;
            if (hold) begin
                it.op    = 2'b00;
                it.done  = 1'b0;
                it.snake = 1'b0;
            end else begin
                idx[d]++;
                if (idx[d] == len[d]) run[d] = 1'b0;
            end
            e_it[d] = it;
        end
    endfunction

    task automatic compare_all();
        check_eq("a_busy",   32'(busy_a),   32'(e_busy[0]));
        check_eq("a_done",   32'(done_a),   32'(e_it[0].done));
        check_eq("a_op",     32'(op_a),     32'(e_it[0].op));
        check_eq("a_parity", 32'(parity_a), 32'(e_it[0].parity));
        check_eq("a_snake",  32'(snake_a),  32'(e_it[0].snake));
        check_eq("a_phase",  32'(phase_a),  32'(e_it[0].phase));
        check_eq("a_step",   32'(step_a),   32'(e_it[0].step));
        check_eq("b_busy",   32'(busy_b),   32'(e_busy[1]));
        check_eq("b_done",   32'(done_b),   32'(e_it[1].done));
        check_eq("b_op",     32'(op_b),     32'(e_it[1].op));
        check_eq("b_parity", 32'(parity_b), 32'(e_it[1].parity));
        check_eq("b_snake",  32'(snake_b),  32'(e_it[1].snake));
        check_eq("b_phase",  32'(phase_b),  32'(e_it[1].phase));
        check_eq("b_step",   32'(step_b),   32'(e_it[1].step));
    endtask

    task automatic tick(input logic sa, input logic ha, input logic sb, input logic hb);
        start_a = sa;
        hold_a  = ha;
        start_b = sb;
        hold_b  = hb;
        @(posedge clk);
        if (rst) begin
            model_edge(0, sa, ha);
            model_edge(1, sb, hb);
        end else begin
            model_idle(0);
            model_idle(1);
        end
        #1;
        compare_all();
    endtask

    task automatic async_reset(input int cycles);
        rst = 1'b0;
        #1;
        model_idle(0);
        model_idle(1);
        compare_all();
        for (int i = 0; i < cycles; i++) tick(1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
    endtask

    initial begin
        int done_cyc_a, done_cyc_b, xchg_b, snake_b_cnt, snake_odd_b, done_cnt, idle_run;
        bit found, seen_done;

        build(0, 2, 1, 1, 1);
        build(1, 4, 2, 2, 3);
        model_idle(0);
        model_idle(1);
        rst = 1'b1;
        start_a = 1'b0; hold_a = 1'b0; start_b = 1'b0; hold_b = 1'b0;
        #2;
        async_reset(2);

        // Basic run on A and stretched run on B, both started at cycle 0
        done_cyc_a = -1; done_cyc_b = -1; xchg_b = 0; snake_b_cnt = 0; snake_odd_b = 0;
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 50; c++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (c == 1) check_eq("a_first_row", 32'(op_a), 32'd1);
            if (c == 3) check_eq("a_c3_phase", 32'(phase_a), 32'd1);
            if (c == 9) check_eq("a_busy_after", 32'(busy_a), 32'd0);
            if (done_a && done_cyc_a < 0) done_cyc_a = c;
            if (done_b && done_cyc_b < 0) done_cyc_b = c;
            if (op_b == 2'b01 || op_b == 2'b10) xchg_b++;
            if (snake_b) snake_b_cnt++;
            if (snake_b && phase_b[0]) snake_odd_b++;
        end
        check_eq("a_done_cycle", 32'(done_cyc_a), 32'd8);
        check_eq("b_done_cycle", 32'(done_cyc_b), 32'd44);
        check_eq("b_xchg_cycles", 32'(xchg_b), 32'd40);
        check_eq("b_snake_cycles", 32'(snake_b_cnt), 32'd24);
        check_eq("b_snake_odd", 32'(snake_odd_b), 32'd0);

        // Hold in cycles 3-4 stretches the run by two cycles
        done_cyc_a = -1;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 14; c++) begin
            tick(1'b0, (c == 3 || c == 4), 1'b0, 1'b0);
            if (c == 3) check_eq("hold_op", 32'(op_a), 32'd0);
            if (c == 4) check_eq("hold_busy", 32'(busy_a), 32'd1);
            if (c == 5) check_eq("resume_op", 32'(op_a), 32'd2);
            if (c == 5) check_eq("resume_phase", 32'(phase_a), 32'd1);
            if (done_a && done_cyc_a < 0) done_cyc_a = c;
        end
        check_eq("hold_done_cycle", 32'(done_cyc_a), 32'd10);

        // Reset during phase 1 step 1, no done pulse, then a clean restart
        found = 1'b0;
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        for (int c = 1; c <= 20; c++) begin
            if (!found) begin
                tick(1'b0, 1'b0, 1'b0, 1'b0);
                if (phase_a == 4'd1 && step_a == 1'b1) found = 1'b1;
            end
        end
        check_eq("midrun_reached", 32'(found), 32'd1);
        async_reset(2);
        check_eq("midrun_busy", 32'(busy_a), 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 6; c++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (done_a || done_b) done_cnt++;
        end
        check_eq("abort_no_done", 32'(done_cnt), 32'd0);
        done_cyc_a = -1;
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        for (int c = 1; c <= 12; c++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0);
            if (c == 1) check_eq("restart_phase", 32'(phase_a), 32'd0);
            if (done_a && done_cyc_a < 0) done_cyc_a = c;
        end
        check_eq("restart_done_cycle", 32'(done_cyc_a), 32'd8);

        // i_start held high: back-to-back runs separated by one idle cycle
        done_cnt = 0; idle_run = 0; seen_done = 1'b0;
        for (int c = 0; c <= 40; c++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0);
            if (done_a) begin
                done_cnt++;
                seen_done = 1'b1;
                idle_run = 0;
            end else if (!busy_a) begin
                idle_run++;
            end else if (seen_done) begin
                check_eq("restart_gap", 32'(idle_run), 32'd1);
                seen_done = 1'b0;
            end
        end
        check_eq("back_to_back_runs", 32'(done_cnt), 32'd4);

        // Random start/hold traffic with occasional asynchronous reset
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset(int'($urandom_range(1, 2)));
            end else begin
                tick($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
